// File: rtl/lcd_pkg.sv
// Shared LCD definitions: frame-writer state encoding and the default fill byte.
// Also used by the LCD controller.
package lcd_pkg;

    typedef enum logic [1:0] {
        SNAP = 2'd0,
        ROW  = 2'd1,
        CHAR = 2'd2,
        HOME = 2'd3
    } lcd_state_e;

    // Written in place of a 8'h00 byte in the frame (ASCII space).
    localparam logic [7:0] LCD_FILL_CHAR = 8'h20;

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Command bus between the frame writer (master) and the LCD controller (slave).
// The controller lowers ready while it executes a command.
interface lcd_frame_writer_if;
    logic       ready;
    logic [7:0] char;
    logic       write_char;
    logic       set_row;
    logic [1:0] row_sel;
    logic       home;
    logic       frame_done;

    modport master (
        input  ready,
        output char, write_char, set_row, row_sel, home, frame_done
    );

    modport slave (
        output ready,
        input  char, write_char, set_row, row_sel, home, frame_done
    );
endinterface

// File: rtl/lcd_char_sel.sv
// Combinational byte pick from the frame snapshot at (row, col).
// A null byte is replaced by FILL_CHAR so that blank cells show as spaces.
module lcd_char_sel #(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 2,
    parameter int         CW        = 4,
    parameter int         RW        = 1,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic [ROWS*COLS*8-1:0] snap,
    input  logic [RW-1:0]          row,
    input  logic [CW-1:0]          col,
    output logic [7:0]             ch
);

    logic [7:0] raw;

    // Byte (r,c) sits at index r*COLS+c; byte 0 is row 0 col 0.
    always_comb begin
        raw = snap[(int'(row) * COLS + int'(col)) * 8 +: 8];
        ch  = (raw == 8'h00) ? FILL_CHAR : raw;
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Streams a ROWS x COLS character frame to the LCD controller: per row a
// set-cursor command then COLS character writes, one home command per frame.
// Optional LCD_FRAME_DIRTY_SKIP_EN: rows unchanged since their last write
// are skipped (no set_row, no chars); home is still issued every frame.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int         COLS      = 16,
    parameter int         ROWS      = 2,
    parameter logic [7:0] FILL_CHAR = LCD_FILL_CHAR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS*8-1:0] frame,
    lcd_frame_writer_if.master     lcd
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    lcd_state_e             state;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic [ROWS*COLS*8-1:0] snap;
    logic [7:0]             sel_char;

    logic [7:0] char_q;
    logic       write_char_q, set_row_q, home_q, frame_done_q;
    logic [1:0] row_sel_q;

    logic busy, go, row_clean;

    // A strobe stays up until the controller shows ready=0; a new command
    // may only start once every strobe is low and ready is back.
    assign busy = write_char_q | set_row_q | home_q;
    assign go   = lcd.ready & ~busy;

    lcd_char_sel #(
        .COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW), .FILL_CHAR(FILL_CHAR)
    ) u_char_sel (
        .snap(snap), .row(row), .col(col), .ch(sel_char)
    );

`ifdef LCD_FRAME_DIRTY_SKIP_EN
    logic [ROWS-1:0][COLS*8-1:0] shadow;
    logic [ROWS-1:0]             shadow_vld;

    assign row_clean = shadow_vld[row] &&
                       (shadow[row] == snap[int'(row) * COLS * 8 +: COLS * 8]);
`else
    assign row_clean = 1'b0;
`endif

    // Command sequencer: snapshot, rows of set_row + chars, then home.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SNAP;
            row          <= '0;
            col          <= '0;
            char_q       <= '0;
            write_char_q <= 1'b0;
            set_row_q    <= 1'b0;
            row_sel_q    <= '0;
            home_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_FRAME_DIRTY_SKIP_EN
            shadow_vld   <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            if (busy && !lcd.ready) begin
                write_char_q <= 1'b0;
                set_row_q    <= 1'b0;
                home_q       <= 1'b0;
            end
            case (state)
                SNAP: begin
                    snap  <= frame;
                    row   <= '0;
                    col   <= '0;
                    state <= ROW;
                end
                ROW: begin
                    if (row_clean) begin
                        // Unchanged row: move on without touching the LCD.
                        if (row == ROW_LAST) state <= HOME;
                        else                 row   <= row + RW'(1);
                    end else if (go) begin
                        set_row_q <= 1'b1;
                        row_sel_q <= 2'(row);
                        col       <= '0;
                        state     <= CHAR;
                    end
                end
                CHAR: begin
                    if (go) begin
                        char_q       <= sel_char;
                        write_char_q <= 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
`ifdef LCD_FRAME_DIRTY_SKIP_EN
                            shadow[row]     <= snap[int'(row) * COLS * 8 +: COLS * 8];
                            shadow_vld[row] <= 1'b1;
`endif
                            if (row == ROW_LAST) begin
                                state <= HOME;
                            end else begin
                                row   <= row + RW'(1);
                                state <= ROW;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                HOME: begin
                    if (go) begin
                        home_q       <= 1'b1;
                        frame_done_q <= 1'b1;
                        state        <= SNAP;
                    end
                end
                default: state <= SNAP;
            endcase
        end
    end

    assign lcd.char       = char_q;
    assign lcd.write_char = write_char_q;
    assign lcd.set_row    = set_row_q;
    assign lcd.row_sel    = row_sel_q;
    assign lcd.home       = home_q;
    assign lcd.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer (COLS=16, ROWS=2). Expected commands
// are queued by the stimulus; a negedge monitor pops one per new strobe.
module tb_lcd_frame_writer;

    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int NB   = ROWS * COLS * 8;
`ifdef LCD_FRAME_DIRTY_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] kind;   // 1 set_row, 2 char, 3 home
        logic [7:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] frame;

    lcd_frame_writer_if bus();

    lcd_frame_writer #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .frame(frame), .lcd(bus)
    );

    always #5 clk = ~clk;

    cmd_t expq[$];
    int   n_cmp = 0, n_bad = 0;
    int   home_cnt = 0, cmd_cnt = 0, r1_chars = 0;
    bit   cur_row1 = 1'b0;
    bit   auto_ready = 1'b1;
    int   drop_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Controller model: ready drops for 3 cycles after each strobe is seen.
    always @(negedge clk) begin
        if (auto_ready) begin
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) bus.ready = 1'b1;
            end else if (bus.set_row || bus.write_char || bus.home) begin
                bus.ready = 1'b0;
                drop_cnt  = 3;
            end
        end
    end

    // Monitor: each rising strobe is one command, compared with the queue head.
    logic p_sr = 1'b0, p_wc = 1'b0, p_hm = 1'b0;
    always @(negedge clk) begin
        cmd_t a, e;
        bit   rise;
        rise = 1'b0;
        a    = '0;
        if (bus.set_row && !p_sr) begin
            a = {2'd1, 6'd0, bus.row_sel}; rise = 1'b1;
        end else if (bus.write_char && !p_wc) begin
            a = {2'd2, bus.char}; rise = 1'b1;
        end else if (bus.home && !p_hm) begin
            a = {2'd3, 8'h00}; rise = 1'b1;
            chk("frame_done_with_home", 16'(bus.frame_done), 16'd1);
            home_cnt++;
        end
        if (bus.home && p_hm) chk("frame_done_one_cycle", 16'(bus.frame_done), 16'd0);
        if ((int'(bus.set_row) + int'(bus.write_char) + int'(bus.home)) > 1)
            chk("one_strobe", {13'd0, bus.set_row, bus.write_char, bus.home}, 16'd0);
        if (rise) begin
            cmd_cnt++;
            if (a.kind == 2'd1) begin
                cur_row1 = (bus.row_sel == 2'd1);
                r1_chars = 0;
            end else if (a.kind == 2'd2 && cur_row1) begin
                r1_chars++;
            end
            if (expq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_cmd: got %h expected none", a);
            end else begin
                e = expq.pop_front();
                chk("cmd", 16'(a), 16'(e));
            end
        end
        p_sr = bus.set_row;
        p_wc = bus.write_char;
        p_hm = bus.home;
    end

    task automatic push_frame(input logic [NB-1:0] f, input logic [ROWS-1:0] mask);
        logic [7:0] b;
        for (int r = 0; r < ROWS; r++) begin
            if (mask[r]) begin
                expq.push_back({2'd1, 8'(r)});
                for (int c = 0; c < COLS; c++) begin
                    b = f[(r * COLS + c) * 8 +: 8];
                    expq.push_back({2'd2, (b == 8'h00) ? 8'h20 : b});
                end
            end
        end
        expq.push_back({2'd3, 8'h00});
    endtask

    task automatic wait_home(input int n);
        int k;
        k = 0;
        while (home_cnt < n && k < 3000) begin
            @(negedge clk); #1; k++;
        end
        chk("home_reached", 16'(home_cnt >= n), 16'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_char"},       16'(bus.char),       16'd0);
        chk({tag, "_write_char"}, 16'(bus.write_char), 16'd0);
        chk({tag, "_set_row"},    16'(bus.set_row),    16'd0);
        chk({tag, "_row_sel"},    16'(bus.row_sel),    16'd0);
        chk({tag, "_home"},       16'(bus.home),       16'd0);
        chk({tag, "_frame_done"}, 16'(bus.frame_done), 16'd0);
    endtask

    logic [NB-1:0] fa, fb, fc;
    string         row_txt;
    int            k, cmd_base;

    initial begin
        // Both rows "AAAABBBBCCCCABCD"; (0,5) and (1,15) null -> emitted as 20.
        row_txt = "AAAABBBBCCCCABCD";
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fa[(r * COLS + c) * 8 +: 8] = row_txt[c];
        fa[(0 * COLS + 5)  * 8 +: 8] = 8'h00;
        fa[(1 * COLS + 15) * 8 +: 8] = 8'h00;
        fb = fa;
        fb[(1 * COLS + 3) * 8 +: 8] = 8'h5A;    // 'Z' in row 1 col 3
        fc = fb;
        fc[(0 * COLS + 0) * 8 +: 8] = 8'h51;    // 'Q' in row 0 col 0

        bus.ready = 1'b1;
        frame     = fa;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("reset");

        // Hand-written head of frame 1: set_row(0), 41 41 41 41 42 20 ...
        expq.push_back({2'd1, 8'h00});
        expq.push_back({2'd2, 8'h41}); expq.push_back({2'd2, 8'h41});
        expq.push_back({2'd2, 8'h41}); expq.push_back({2'd2, 8'h41});
        expq.push_back({2'd2, 8'h42}); expq.push_back({2'd2, 8'h20});
        for (int c = 6; c < COLS; c++)
            expq.push_back({2'd2, fa[c * 8 +: 8]});
        expq.push_back({2'd1, 8'h01});
        for (int c = 0; c < COLS; c++)
            expq.push_back({2'd2, (c == 15) ? 8'h20 : fa[(COLS + c) * 8 +: 8]});
        expq.push_back({2'd3, 8'h00});
        rst = 1'b0;
        wait_home(1);
        chk("frame1_cmd_count", 16'(cmd_cnt), 16'd35);

        // Frame 2 snapshots fa on the next edge; fb appears only afterwards.
        push_frame(fa, SKIP ? 2'b00 : 2'b11);
        push_frame(fb, SKIP ? 2'b10 : 2'b11);
        @(posedge clk);
        @(negedge clk); #1;
        frame = fb;
        wait_home(2);

        // Reset while the 5th char of row 1 (frame 3) is on the bus.
        k = 0;
        while (!(r1_chars == 5 && bus.write_char) && k < 3000) begin
            @(negedge clk); #1; k++;
        end
        chk("reached_row1_char5", 16'(bus.write_char), 16'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk_idle_outputs("midrst");
        expq.delete();
        push_frame(fb, 2'b11);
        rst = 1'b0;
        wait_home(3);

        push_frame(fb, SKIP ? 2'b00 : 2'b11);
        wait_home(4);

        // Ready stays high after the next strobe: it must never be released.
        auto_ready = 1'b0;
        bus.ready  = 1'b0;
        frame      = fc;
        cmd_base   = cmd_cnt;
        expq.push_back({2'd1, 8'h00});
        repeat (3) @(negedge clk);
        bus.ready = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        chk("hold_set_row",    16'(bus.set_row),     16'd1);
        chk("hold_write_char", 16'(bus.write_char),  16'd0);
        chk("hold_home",       16'(bus.home),        16'd0);
        chk("hold_cmd_count",  16'(cmd_cnt - cmd_base), 16'd1);
        chk("queue_drained",   16'(expq.size()),     16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
- Parametrised successor to the single-line LCD writer: streams a full ROWS x COLS character frame to the LCD command driver.
- Snapshots the frame, then per row issues a cursor-position command followed by COLS character writes; ends each frame with a home command.
- Sits between the status/formatting logic (frame source) and the LCD controller (ready/strobe consumer).

Parameters:
- COLS, 16, characters per row (1..64).
- ROWS, 2, number of display rows (1..4).
- FILL_CHAR, 8'h20, byte substituted for 8'h00 in the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ready  in  1  LCD controller idle/accepting; drops while executing a command.
- frame  in  ROWS*COLS*8  character data; char (r,c) at frame[(r*COLS+c)*8 +: 8], byte 0 = row 0 col 0.
- char  out  8  character byte, valid while write_char=1.
- write_char  out  1  write-character strobe.
- set_row  out  1  set-cursor strobe (cursor to column 0 of row_sel).
- row_sel  out  2  target row for set_row.
- home  out  1  home-cursor strobe.
- frame_done  out  1  one-cycle pulse on the cycle home is asserted.

Behaviour:
- Reset: char=0, write_char=0, set_row=0, row_sel=0, home=0, frame_done=0, state=SNAP, row=0, col=0. Reset mid-command drops any strobe the next cycle; no partial-frame resume.
- Handshake: an action starts only on a clk edge with ready=1 and all strobes low. The strobe is then held until ready=0 is sampled, and all strobes clear that edge. The next action cannot start before the following ready=1 edge. At most one strobe is high at any time.
- States:
  - SNAP: copy frame into an internal snapshot; row=0; move to ROW. No handshake is needed, 1 cycle. frame changes after SNAP do not affect the frame in flight.
  - ROW: on handshake start, set_row=1, row_sel=row, col=0; move to CHAR.
  - CHAR: on handshake start, char=snapshot(row,col) if nonzero, else FILL_CHAR; write_char=1; col++.
    - Last column (col==COLS-1): if row<ROWS-1, row++ and go to ROW; else go to HOME.
  - HOME: on handshake start, home=1, frame_done=1 for that single cycle; go to SNAP.
- Counters: col is $clog2(COLS) bits wide and row is $clog2(ROWS) bits wide, minimum 1 bit each. They never wrap silently; the terminal compares are exact.
- Per frame: ROWS*(COLS+1)+1 commands. Frames repeat continuously.
- ready held high with no drop: the first strobe stays high indefinitely and there is no progress. This is required, not a bug.
- ready=0 while idle: no action and outputs hold.

Optional Feature:
- Macro LCD_FRAME_DIRTY_SKIP_EN.
- Enabled:
  - A per-row shadow of the last written content is kept.
  - In ROW, a row whose snapshot equals its shadow is skipped: no set_row and no chars. Evaluation moves to the next row, one cycle per skipped row.
  - The shadow updates for a row after its last char is issued.
  - The shadow is invalid after reset, so the first frame writes all rows.
  - home and frame_done are still issued every frame.
- Disabled: every row is written every frame; no shadow storage.

Decomposition:
- Package lcd_pkg: state encoding (SNAP, ROW, CHAR, HOME) and the default FILL_CHAR constant. The package is shared with the LCD controller.
- Sub-module lcd_char_sel: combinational snapshot (row,col) byte select plus the null-to-FILL_CHAR substitution.

Test Plan:
- COLS=16, ROWS=2, frame "AAAABBBBCCCCABCD" on both rows; ready modelled as a 3-cycle drop per strobe -> set_row(0), 16 chars 41,41,41,41,42,...,44, set_row(1), same 16 chars, home+frame_done. 35 commands total, then repeat.
- Frame bytes at (0,5) and (1,15) = 8'h00 -> those writes emit 8'h20.
- ready held high, never dropped -> set_row stays 1, no further strobes.
- rst asserted while write_char=1 mid-row 1 -> all outputs 0 next cycle; restart begins with set_row row_sel=0.
- frame changed on the cycle after SNAP -> current frame emits the old data; the next frame emits the new data.
- DIRTY_SKIP_EN: the second identical frame emits home only; change row 1 col 3 -> only set_row(1) + 16 chars + home.
